// File: rtl/cpu_pkg.sv
// Shared definitions for the 8227 core front end.
//   phase_t : sequencer phase encoding (FETCH, DECODE, ADDR, OP)
//   OPC_BRK : opcode injected in place of a fetch when an interrupt is taken
//   T_W     : width of the decoder timing codes and of the T-state index
package cpu_pkg;

    localparam int         T_W     = 3;
    localparam logic [7:0] OPC_BRK = 8'h00;

    typedef enum logic [1:0] {
        PH_FETCH  = 2'd0,
        PH_DECODE = 2'd1,
        PH_ADDR   = 2'd2,
        PH_OP     = 2'd3
    } phase_t;

endpackage

// File: rtl/tstate_counter.sv
// Loadable T-state counter shared by the ADDR and OP phases.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance one T-state (ignored once the terminal state is reached)
//   load     : restart at index 0 with len cycles to run (len must be >= 1)
//   len      : number of cycles for the phase being entered
//   t_count  : cycle index within the phase, counting up from 0
//   last     : high on the final cycle of the loaded length
module tstate_counter #(
    parameter int T_W = cpu_pkg::T_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           load,
    input  logic [T_W-1:0] len,
    output logic [T_W-1:0] t_count,
    output logic           last
);

    logic [T_W-1:0] r_t;
    logic [T_W-1:0] r_rem;   // cycles remaining after the current one

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_t   <= '0;
            r_rem <= '0;
        end else if (load) begin
            r_t   <= '0;
            r_rem <= len - T_W'(1);
        end else if (en && (r_rem != '0)) begin
            r_t   <= r_t + T_W'(1);
            r_rem <= r_rem - T_W'(1);
        end
    end

    assign t_count = r_t;
    assign last    = (r_rem == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch and T-state sequencer for the 8227 core.
// Latches the opcode during the sync (FETCH) cycle, then runs the addressing
// and operation phases for the cycle counts the decoder returns. Pending
// NMI/IRQ requests replace the fetched opcode with BRK at the boundary.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   rdy           : bus ready, low freezes all state
//   data_in       : data bus, opcode during the sync cycle
//   addr_timing   : decoder addressing-phase length (sampled in DECODE)
//   op_timing     : decoder operation-phase length, 0 treated as 1
//   nmi_req       : NMI pending (level); irq_req/irq_mask : IRQ pending / I flag
//   opcode        : instruction register
//   phase         : current phase (phase_t)
//   t_count       : cycle index within ADDR/OP, 0 elsewhere
//   sync          : high in FETCH
//   pc_inc        : combinational PC increment request for a real fetch
//   int_ack       : {nmi,irq} one-cycle acknowledge, high during DECODE
module fetch_sequencer #(
    parameter int T_W = cpu_pkg::T_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    input  logic [7:0]     data_in,
    input  logic [T_W-1:0] addr_timing,
    input  logic [T_W-1:0] op_timing,
    input  logic           nmi_req,
    input  logic           irq_req,
    input  logic           irq_mask,
    output logic [7:0]     opcode,
    output logic [1:0]     phase,
    output logic [T_W-1:0] t_count,
    output logic           sync,
    output logic           pc_inc,
    output logic [1:0]     int_ack
);

    import cpu_pkg::*;

    phase_t         r_phase;
    phase_t         w_next_phase;
    logic [7:0]     r_opcode;
    logic [1:0]     r_int_ack;
    logic [T_W-1:0] r_o_len;
    logic           w_inject;
    logic           w_ctr_load;
    logic           w_ctr_en;
    logic           w_last;
    logic [T_W-1:0] w_ctr_len;
    logic [T_W-1:0] w_o_len1;
    logic [T_W-1:0] w_op_len1;

    assign w_inject  = nmi_req | (irq_req & ~irq_mask);
    assign w_o_len1  = (r_o_len   == '0) ? T_W'(1) : r_o_len;
    assign w_op_len1 = (op_timing == '0) ? T_W'(1) : op_timing;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= PH_FETCH;
        end else if (rdy) begin
            r_phase <= w_next_phase;
        end
    end

    // The counter is reloaded on every phase exit so it always reads 0 in
    // FETCH/DECODE; its load on leaving DECODE captures the addressing length.
    always_comb begin
        w_next_phase = r_phase;
        w_ctr_load   = 1'b0;
        w_ctr_en     = 1'b0;
        w_ctr_len    = T_W'(1);
        case (r_phase)
            PH_FETCH: begin
                w_next_phase = PH_DECODE;
            end
            PH_DECODE: begin
                w_ctr_load = rdy;
                if (addr_timing != '0) begin
                    w_next_phase = PH_ADDR;
                    w_ctr_len    = addr_timing;
                end else begin
                    w_next_phase = PH_OP;
                    w_ctr_len    = w_op_len1;
                end
            end
            PH_ADDR: begin
                if (w_last) begin
                    w_next_phase = PH_OP;
                    w_ctr_load   = rdy;
                    w_ctr_len    = w_o_len1;
                end else begin
                    w_ctr_en = rdy;
                end
            end
            PH_OP: begin
                if (w_last) begin
                    w_next_phase = PH_FETCH;
                    w_ctr_load   = rdy;
                end else begin
                    w_ctr_en = rdy;
                end
            end
            default: begin
                w_next_phase = PH_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opcode  <= OPC_BRK;
            r_int_ack <= '0;
            r_o_len   <= '0;
        end else begin
            r_int_ack <= '0;
            if (rdy) begin
                if (r_phase == PH_FETCH) begin
                    if (w_inject) begin
                        r_opcode  <= OPC_BRK;
                        r_int_ack <= nmi_req ? 2'b10 : 2'b01;
                    end else begin
                        r_opcode <= data_in;
                    end
                end else if (r_phase == PH_DECODE) begin
                    r_o_len <= op_timing;
                end
            end
        end
    end

    tstate_counter #(
        .T_W (T_W)
    ) u_tstate (
        .clk     (clk),
        .rst     (rst),
        .en      (w_ctr_en),
        .load    (w_ctr_load),
        .len     (w_ctr_len),
        .t_count (t_count),
        .last    (w_last)
    );

    assign opcode  = r_opcode;
    assign phase   = r_phase;
    assign sync    = (r_phase == PH_FETCH);
    assign pc_inc  = sync & rdy & ~w_inject;
    assign int_ack = r_int_ack;

endmodule
